hub75_scan_driver: RTL

Scan-out stage directly downstream of the line buffer. It reads one buffered row pair, one column per two clocks, and serialises it onto the HUB-75 connector with binary-coded modulation (BCM). It drives shift clock, latch, output enable and the row address, then requests the next row from the upstream fill logic. It owns all panel-facing timing; the line buffer and fill logic never touch HUB-75 pins.

---
 rtl/hub75_pkg.sv | 37 +++
 rtl/hub75_bit_timer.sv | 30 +++
 rtl/hub75_scan_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB-75 scan-out stage: scan states, channel
// field positions within a line-buffer word and bit-plane extraction.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_REQUEST = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;

  localparam int CH_R0           = 0;
  localparam int CH_G0           = 1;
  localparam int CH_B0           = 2;
  localparam int CH_R1           = 3;
  localparam int CH_G1           = 4;
  localparam int CH_B1           = 5;
  localparam int NUM_CHANNELS    = 6;
  localparam int MAX_COLOR_DEPTH = 16;

  // Picks bit 'plane' of every channel field; fields are 'depth' bits wide, R0 lowest.
  function automatic logic [NUM_CHANNELS-1:0] plane_bits(
    input logic [NUM_CHANNELS*MAX_COLOR_DEPTH-1:0] data,
    input int                                      depth,
    input int                                      plane
  );
    logic [NUM_CHANNELS*MAX_COLOR_DEPTH-1:0] shifted;
    logic [NUM_CHANNELS-1:0]                 bits;
    bits = '0;
    for (int ch = CH_R0; ch <= CH_B1; ch++) begin
      shifted  = data >> (ch * depth + plane);
      bits[ch] = shifted[0];
    end
    return bits;
  endfunction

endpackage

// File: rtl/hub75_bit_timer.sv
// Display-time counter for one BCM plane: loads display_base << plane,
// counts down and flags the final on-cycle.
module hub75_bit_timer #(
  parameter int display_base = 4,
  parameter int plane_width  = 3,
  parameter int timer_width  = 10
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_load,
  input  logic [plane_width-1:0] i_plane,
  output logic                   o_done
);

  logic [timer_width-1:0] r_count;

  // Load on entry to the display window, then run down to zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= timer_width'(display_base) << i_plane;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == timer_width'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB-75 scan-out: reads one buffered row pair, shifts each BCM plane onto
// the panel, latches it, shows it for its weighted time, then requests the next row.
module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int panel_width   = 64,
  parameter int address_width = 6,
  parameter int color_depth   = 8,
  parameter int row_bits      = 5,
  parameter int display_base  = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  output logic [address_width-1:0] o_read_address,
  input  logic [6*color_depth-1:0] i_read_data,
  output logic                     o_line_request,
  output logic [row_bits-1:0]      o_line_row,
  input  logic                     i_line_ready,
  output logic [5:0]               o_hub_rgb,
  output logic                     o_hub_clk,
  output logic                     o_hub_lat,
  output logic                     o_hub_oe_n,
  output logic [row_bits-1:0]      o_hub_row
);

  localparam int PLANE_W = (color_depth > 1) ? $clog2(color_depth) : 1;
  localparam int TIMER_W = $clog2((display_base << (color_depth - 1)) + 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(color_depth - 1);
  // The read address runs one column ahead of hub_rgb, so after the last
  // column has been fetched it has already wrapped to this value.
  localparam logic [address_width-1:0] END_ADDR = address_width'(panel_width);

  state_t                                 r_state, w_next_state;
  logic                                   r_phase, w_next_phase;
  logic [PLANE_W-1:0]                     r_plane, w_next_plane;
  logic [row_bits-1:0]                    r_row, w_next_row;
  logic [address_width-1:0]               r_read_address;
  logic                                   r_line_request;
  logic [5:0]                             r_hub_rgb, w_next_rgb;
  logic                                   r_hub_clk, r_hub_lat, r_hub_oe_n;
  logic [row_bits-1:0]                    r_hub_row;
  logic                                   w_load_rgb, w_timer_load, w_timer_done, w_hub_row_load;
  logic [NUM_CHANNELS*MAX_COLOR_DEPTH-1:0] w_read_data_ext;

  hub75_bit_timer #(
    .display_base(display_base),
    .plane_width (PLANE_W),
    .timer_width (TIMER_W)
  ) u_bit_timer (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_load (w_timer_load),
    .i_plane(r_plane),
    .o_done (w_timer_done)
  );

  always_comb begin
    w_read_data_ext                     = '0;
    w_read_data_ext[6*color_depth-1:0]  = i_read_data;
  end

  // Next-state decode; w_load_rgb fetches the column at r_read_address into hub_rgb.
  always_comb begin
    w_next_state   = r_state;
    w_next_phase   = r_phase;
    w_next_plane   = r_plane;
    w_next_row     = r_row;
    w_load_rgb     = 1'b0;
    w_timer_load   = 1'b0;
    w_hub_row_load = 1'b0;
    case (r_state)
      ST_REQUEST: begin
        if (i_line_ready) begin
          w_next_state = ST_SHIFT;
          w_next_phase = 1'b0;
          w_next_plane = '0;
          w_load_rgb   = 1'b1;
        end else begin
          w_next_state = ST_REQUEST;
        end
      end
      ST_SHIFT: begin
        if (!r_phase) begin
          w_next_phase = 1'b1;
        end else if (r_read_address == END_ADDR) begin
          w_next_state   = ST_LATCH;
          w_next_phase   = 1'b0;
          w_hub_row_load = (r_plane == '0);
        end else begin
          w_next_phase = 1'b0;
          w_load_rgb   = 1'b1;
        end
      end
      ST_LATCH: begin
        w_next_state = ST_DISPLAY;
        w_timer_load = 1'b1;
      end
      ST_DISPLAY: begin
        if (!w_timer_done) begin
          w_next_state = ST_DISPLAY;
        end else if (r_plane != LAST_PLANE) begin
          w_next_state = ST_SHIFT;
          w_next_phase = 1'b0;
          w_next_plane = r_plane + 1'b1;
          w_load_rgb   = 1'b1;
        end else begin
          w_next_state = ST_REQUEST;
          w_next_plane = '0;
          w_next_row   = r_row + 1'b1;
        end
      end
      default: begin
        w_next_state = ST_REQUEST;
      end
    endcase
  end

  always_comb begin
    if (w_load_rgb) begin
      w_next_rgb = plane_bits(w_read_data_ext, color_depth, int'(w_next_plane));
    end else begin
      w_next_rgb = r_hub_rgb;
    end
  end

  // Panel-facing outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_REQUEST;
      r_phase        <= 1'b0;
      r_plane        <= '0;
      r_row          <= '0;
      r_read_address <= '0;
      r_line_request <= 1'b0;
      r_hub_rgb      <= 6'd0;
      r_hub_clk      <= 1'b0;
      r_hub_lat      <= 1'b0;
      r_hub_oe_n     <= 1'b1;
      r_hub_row      <= '0;
    end else begin
      r_state        <= w_next_state;
      r_phase        <= w_next_phase;
      r_plane        <= w_next_plane;
      r_row          <= w_next_row;
      r_hub_rgb      <= w_next_rgb;
      r_line_request <= (w_next_state == ST_REQUEST);
      r_hub_clk      <= (w_next_state == ST_SHIFT) && w_next_phase;
      r_hub_lat      <= (w_next_state == ST_LATCH);
      r_hub_oe_n     <= (w_next_state != ST_DISPLAY);
      if (w_load_rgb) begin
        r_read_address <= r_read_address + 1'b1;
      end else if (w_next_state != ST_SHIFT) begin
        r_read_address <= '0;
      end
      if (w_hub_row_load) begin
        r_hub_row <= r_row;
      end
    end
  end

  assign o_read_address = r_read_address;
  assign o_line_request = r_line_request;
  assign o_line_row     = r_row;
  assign o_hub_rgb      = r_hub_rgb;
  assign o_hub_clk      = r_hub_clk;
  assign o_hub_lat      = r_hub_lat;
  assign o_hub_oe_n     = r_hub_oe_n;
  assign o_hub_row      = r_hub_row;

endmodule
